// File: rtl/lab3_seq_pkg.sv
// Shared types and sizes for the lab3 stimulus sequencer.
// Latency: none (declarations only).
// Backpressure: none.
package lab3_seq_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} seq_state_t;

    localparam int NVEC  = 8;
    localparam int RES_W = 2*NVEC;

endpackage

// File: rtl/lab3_dwell_cnt.sv
// Dwell counter: counts 0..DWELL-1 while enabled; flags the last cycle of each dwell.
// Latency: last is combinational from the registered count, valid in the same cycle.
// Backpressure: none; clr has priority over en.
module lab3_dwell_cnt #(
    parameter int DWELL = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int              CW       = $clog2(DWELL+1);
    localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL-1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise advance while the sequencer is driving.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With DWELL=1 the count stays at 0, so every enabled cycle is the last one.
    assign last = en && (cnt_q == LAST_CNT);

endmodule

// File: rtl/lab3_stim_seq.sv
// Sweeps {a,b,c} through 000..111, holding each vector DWELL cycles, and captures {x,y}.
// Latency: busy/vector 000 one cycle after start; done 8*DWELL+1 cycles after start.
// Backpressure: none; start is only honoured in IDLE and is never queued.
module lab3_stim_seq
    import lab3_seq_pkg::*;
#(
    parameter int DWELL = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             x,
    input  logic             y,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] results
);

    localparam logic [2:0] LAST_IDX = 3'(NVEC-1);

    if (DWELL < 1) begin : g_bad_dwell
        $error("lab3_stim_seq: DWELL must be at least 1");
    end

    seq_state_t       state_q;
    logic [2:0]       idx_q;
    logic [2:0]       abc_q;
    logic             busy_q;
    logic             done_q;
    logic [RES_W-1:0] results_q;

    logic             accept;
    logic             dwell_en;
    logic             dwell_clr;
    logic             dwell_last;

    assign accept    = (state_q == IDLE) && start;
    assign dwell_en  = (state_q == DRIVE);
    assign dwell_clr = accept || dwell_last;

    lab3_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (dwell_clr),
        .en   (dwell_en),
        .last (dwell_last)
    );

    // Sweep FSM with registered stimulus, status and capture outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            abc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            results_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        results_q <= '0;
                        idx_q     <= '0;
                        abc_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (dwell_last) begin
                        // x,y have settled for a full dwell against the current vector.
                        results_q[{idx_q, 1'b0} +: 2] <= {x, y};
                        if (idx_q == LAST_IDX) begin
                            abc_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            abc_q <= idx_q + 3'd1;
                        end
                    end
                end
                DONE: begin
                    idx_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign {a, b, c} = abc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign results   = results_q;

endmodule

// File: tb/tb_lab3_stim_seq.sv
// Bench for lab3_stim_seq: two instances (DWELL=10 and DWELL=1) in front of a lab3 stand-in.
// A sweep-level model predicts every output each cycle; directed tests pin timing and results.
module tb_lab3_stim_seq;

    logic        clk;
    logic        rst;
    logic [1:0]  start_s;
    logic [1:0]  x_s, y_s, a_s, b_s, c_s, busy_s, done_s;
    logic [15:0] res0, res1;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int es     = 0;

    // monitor records
    int dq0[$];
    int dq1[$];
    int busy_n[2];

    // model state: sweep active, edges since accepted start, captured table
    bit          m_act[2];
    int          m_t[2];
    logic [15:0] m_res[2];

    lab3_stim_seq #(.DWELL(10)) u_d10 (
        .clk(clk), .rst(rst), .start(start_s[0]), .x(x_s[0]), .y(y_s[0]),
        .a(a_s[0]), .b(b_s[0]), .c(c_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .results(res0)
    );

    lab3_stim_seq #(.DWELL(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .x(x_s[1]), .y(y_s[1]),
        .a(a_s[1]), .b(b_s[1]), .c(c_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .results(res1)
    );

    // lab3 stand-in: x = parity, y = majority
    assign x_s[0] = a_s[0] ^ b_s[0] ^ c_s[0];
    assign y_s[0] = (a_s[0] & b_s[0]) | (a_s[0] & c_s[0]) | (b_s[0] & c_s[0]);
    assign x_s[1] = a_s[1] ^ b_s[1] ^ c_s[1];
    assign y_s[1] = (a_s[1] & b_s[1]) | (a_s[1] & c_s[1]) | (b_s[1] & c_s[1]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] lab3_ref(input int i);
        logic [2:0] v;
        v = i[2:0];
        lab3_ref = {^v, (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0])};
    endfunction

    function automatic int dwell_of(input int k);
        dwell_of = (k == 0) ? 10 : 1;
    endfunction

    // Sweep model: a sweep lasts 8*D driving cycles plus one done cycle.
    always @(posedge clk or posedge rst) begin
        int d;
        int i;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_act[k] = 1'b0;
                m_t[k]   = 0;
                m_res[k] = 16'h0000;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                d = dwell_of(k);
                if (m_act[k]) begin
                    m_t[k] = m_t[k] + 1;
                    if ((m_t[k] % d) == 0 && m_t[k] <= 8*d) begin
                        i = m_t[k]/d - 1;
                        m_res[k][2*i +: 2] = lab3_ref(i);
                    end
                    if (m_t[k] == 8*d + 1) m_act[k] = 1'b0;
                end else if (start_s[k]) begin
                    m_act[k] = 1'b1;
                    m_t[k]   = 0;
                    m_res[k] = 16'h0000;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, plus done/busy monitoring.
    always @(negedge clk) begin
        int d;
        logic [20:0] expv;
        logic [20:0] actv;
        for (int k = 0; k < 2; k++) begin
            d = dwell_of(k);
            expv = {3'b000, 1'b0, 1'b0, m_res[k]};
            if (m_act[k] && m_t[k] < 8*d) begin
                expv[20:18] = 3'(m_t[k]/d);
                expv[17]    = 1'b1;
            end else if (m_act[k] && m_t[k] == 8*d) begin
                expv[16] = 1'b1;
            end
            actv = {a_s[k], b_s[k], c_s[k], busy_s[k], done_s[k], (k == 0) ? res0 : res1};
            check((k == 0) ? "cycle_d10" : "cycle_d1", int'(actv), int'(expv));
            if (busy_s[k]) busy_n[k]++;
        end
        if (done_s[0]) dq0.push_back(cyc);
        if (done_s[1]) dq1.push_back(cyc);
    end

    task automatic clr_mon();
        dq0.delete();
        dq1.delete();
        busy_n[0] = 0;
        busy_n[1] = 0;
    endtask

    // One-edge start pulse; es is the edge index that samples it (cycle 0).
    task automatic pulse(input int k);
        @(posedge clk); #2;
        start_s[k] = 1'b1;
        es = cyc + 1;
        @(posedge clk); #2;
        start_s[k] = 1'b0;
    endtask

    function automatic int dcyc(input int e);
        dcyc = e - es + 1;
    endfunction

    initial begin
        rst     = 1'b1;
        start_s = 2'b00;
        busy_n[0] = 0;
        busy_n[1] = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // idle after reset
        clr_mon();
        repeat (20) @(posedge clk);
        #2;
        check("idle_res_d10", int'(res0), 16'h0000);
        check("idle_res_d1", int'(res1), 16'h0000);
        check("idle_busy", busy_n[0] + busy_n[1], 0);
        check("idle_done", dq0.size() + dq1.size(), 0);

        // DWELL=10 single sweep
        clr_mon();
        pulse(0);
        repeat (90) @(posedge clk);
        #2;
        check("d10_done_cnt", dq0.size(), 1);
        check("d10_done_cyc", (dq0.size() > 0) ? dcyc(dq0[0]) : -1, 81);
        check("d10_busy_len", busy_n[0], 80);
        check("d10_results", int'(res0), 16'hD668);

        // DWELL=1 single sweep
        clr_mon();
        pulse(1);
        repeat (15) @(posedge clk);
        #2;
        check("d1_done_cnt", dq1.size(), 1);
        check("d1_done_cyc", (dq1.size() > 0) ? dcyc(dq1[0]) : -1, 9);
        check("d1_busy_len", busy_n[1], 8);
        check("d1_results", int'(res1), 16'hD668);

        // start re-pulsed at cycles 5 and 40 is ignored
        clr_mon();
        pulse(0);
        repeat (4) @(posedge clk);
        #2 start_s[0] = 1'b1;
        @(posedge clk);
        #2 start_s[0] = 1'b0;
        repeat (34) @(posedge clk);
        #2 start_s[0] = 1'b1;
        @(posedge clk);
        #2 start_s[0] = 1'b0;
        repeat (50) @(posedge clk);
        #2;
        check("repulse_done_cnt", dq0.size(), 1);
        check("repulse_done_cyc", (dq0.size() > 0) ? dcyc(dq0[0]) : -1, 81);
        check("repulse_busy_len", busy_n[0], 80);
        check("repulse_results", int'(res0), 16'hD668);

        // asynchronous reset during cycle 35
        clr_mon();
        pulse(0);
        repeat (34) @(posedge clk);
        #2;
        check("pre_rst_busy", int'(busy_s[0]), 1);
        rst = 1'b1;
        #1;
        check("rst_async_abc", int'({a_s[0], b_s[0], c_s[0]}), 0);
        check("rst_async_busy", int'(busy_s[0]), 0);
        check("rst_async_res", int'(res0), 16'h0000);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (60) @(posedge clk);
        #2;
        check("rst_no_done", dq0.size(), 0);
        check("rst_res_clear", int'(res0), 16'h0000);
        clr_mon();
        pulse(0);
        repeat (90) @(posedge clk);
        #2;
        check("post_rst_done_cyc", (dq0.size() > 0) ? dcyc(dq0[0]) : -1, 81);
        check("post_rst_results", int'(res0), 16'hD668);

        // start held high: back-to-back sweeps
        clr_mon();
        @(posedge clk); #2;
        start_s[0] = 1'b1;
        es = cyc + 1;
        repeat (200) @(posedge clk);
        #2 start_s[0] = 1'b0;
        repeat (60) @(posedge clk);
        #2;
        check("hold_done_cnt", dq0.size(), 3);
        check("hold_done1_cyc", (dq0.size() > 0) ? dcyc(dq0[0]) : -1, 81);
        check("hold_done2_cyc", (dq0.size() > 1) ? dcyc(dq0[1]) : -1, 163);
        check("hold_busy_len", busy_n[0], 240);
        check("hold_results", int'(res0), 16'hD668);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
